// File: rtl/uart_tx_fifo_rd.sv
// UART transmitter that pops bytes from a non-FWFT synchronous FIFO and
// serialises them as start / data (LSB first) / optional parity / stop bits.
module uart_tx_fifo_rd #(
  parameter int DataWidth  = 8,
  parameter int ClksPerBit = 434,
  parameter int Parity     = 0,
  parameter int StopBits   = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_enable,
  input  logic                 i_empty,
  input  logic [DataWidth-1:0] i_rd_data,
  output logic                 o_rd_en,
  output logic                 o_tx,
  output logic                 o_busy
);

  localparam int BaudW = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam int BitW  = $clog2(DataWidth + 1);

  localparam logic [BaudW-1:0] BaudLast = BaudW'(ClksPerBit - 1);
  localparam logic [BitW-1:0]  DataLast = BitW'(DataWidth - 1);
  localparam logic [BitW-1:0]  StopLast = BitW'(StopBits - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LOAD,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [BaudW-1:0]     r_baud_cnt;
  logic [BaudW-1:0]     w_baud_cnt_next;
  logic [BitW-1:0]      r_bit_cnt;
  logic [BitW-1:0]      w_bit_cnt_next;
  logic [DataWidth-1:0] r_shift;
  logic [DataWidth-1:0] w_shift_next;
  logic                 r_parity;
  logic                 w_parity_next;
  logic                 r_tx;
  logic                 w_tx_next;
  logic                 r_rd_en;
  logic                 w_rd_en_next;
  logic                 r_busy;
  logic                 w_busy_next;
  logic                 w_baud_last;
  logic                 w_on_line;

  assign w_baud_last = (r_baud_cnt == BaudLast);
  assign w_on_line   = (r_state == S_START) || (r_state == S_DATA) ||
                       (r_state == S_PARITY) || (r_state == S_STOP);

  // State and all registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_tx       <= 1'b1;
      r_rd_en    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_baud_cnt <= w_baud_cnt_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_shift    <= w_shift_next;
      r_parity   <= w_parity_next;
      r_tx       <= w_tx_next;
      r_rd_en    <= w_rd_en_next;
      r_busy     <= w_busy_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (i_enable && !i_empty) w_state_next = S_POP;
      S_POP:    w_state_next = S_LOAD;
      S_LOAD:   w_state_next = S_START;
      S_START:  if (w_baud_last) w_state_next = S_DATA;
      S_DATA: begin
        if (w_baud_last && (r_bit_cnt == DataLast))
          w_state_next = (Parity != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: if (w_baud_last) w_state_next = S_STOP;
      S_STOP:   if (w_baud_last && (r_bit_cnt == StopLast)) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Counters, shift register and parity capture
  always_comb begin
    w_baud_cnt_next = '0;
    if (w_on_line && !w_baud_last)
      w_baud_cnt_next = r_baud_cnt + BaudW'(1);

    // Bit counter is reused for stop bits; it clears on every state change
    w_bit_cnt_next = r_bit_cnt;
    if (w_state_next != r_state)
      w_bit_cnt_next = '0;
    else if (w_baud_last && ((r_state == S_DATA) || (r_state == S_STOP)))
      w_bit_cnt_next = r_bit_cnt + BitW'(1);

    w_shift_next  = r_shift;
    w_parity_next = r_parity;
    if (r_state == S_LOAD) begin
      w_shift_next  = i_rd_data;
      w_parity_next = (Parity == 2) ? ~(^i_rd_data) : (^i_rd_data);
    end else if ((r_state == S_DATA) && w_baud_last) begin
      w_shift_next = r_shift >> 1;
    end
  end

  // Outputs are registered, so they are decoded from the upcoming state
  always_comb begin
    w_rd_en_next = (w_state_next == S_POP);
    w_busy_next  = (w_state_next != S_IDLE);
    w_tx_next    = 1'b1;
    case (w_state_next)
      S_START:  w_tx_next = 1'b0;
      S_DATA:   w_tx_next = w_shift_next[0];
      S_PARITY: w_tx_next = w_parity_next;
      default:  w_tx_next = 1'b1;
    endcase
  end

  assign o_rd_en = r_rd_en;
  assign o_tx    = r_tx;
  assign o_busy  = r_busy;

endmodule

// File: tb/tb_uart_tx_fifo_rd.sv
// Bench for uart_tx_fifo_rd: three instances (no parity / even / odd with two
// stop bits) fed by FIFO models and compared every cycle against a frame-offset model.
module tb_uart_tx_fifo_rd;

  localparam int Cpb = 4;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] empty;
  logic [7:0] rd_data [3];
  logic [2:0] rd_en_w;
  logic [2:0] tx_w;
  logic [2:0] busy_w;

  int tests;
  int fails;
  int cyc;

  logic [7:0] fmem [3][1024];
  int         head [3];
  int         tail [3];
  logic [2:0] rd_seen;

  logic       active [3];
  int         t0     [3];
  logic [7:0] fbyte  [3];

  uart_tx_fifo_rd #(.DataWidth(8), .ClksPerBit(Cpb), .Parity(0), .StopBits(1)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_empty(empty[0]),
    .i_rd_data(rd_data[0]), .o_rd_en(rd_en_w[0]), .o_tx(tx_w[0]), .o_busy(busy_w[0]));

  uart_tx_fifo_rd #(.DataWidth(8), .ClksPerBit(Cpb), .Parity(1), .StopBits(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_empty(empty[1]),
    .i_rd_data(rd_data[1]), .o_rd_en(rd_en_w[1]), .o_tx(tx_w[1]), .o_busy(busy_w[1]));

  uart_tx_fifo_rd #(.DataWidth(8), .ClksPerBit(Cpb), .Parity(2), .StopBits(2)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_empty(empty[2]),
    .i_rd_data(rd_data[2]), .o_rd_en(rd_en_w[2]), .o_tx(tx_w[2]), .o_busy(busy_w[2]));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int frame_len(input int k);
    return (1 + 8 + ((k != 0) ? 1 : 0) + ((k == 2) ? 2 : 1)) * Cpb;
  endfunction

  // Line level of bit slot idx within a frame carrying byte b
  function automatic logic exp_bit(input int k, input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (idx == 9 && k != 0) return (k == 1) ? ^b : ~(^b);
    return 1'b1;
  endfunction

  task automatic check_dut(input int k);
    logic e_tx, e_busy, e_rd;
    int   d;
    e_tx = 1'b1; e_busy = 1'b0; e_rd = 1'b0;
    if (active[k]) begin
      d = cyc - t0[k];
      if (d >= 3 + frame_len(k)) begin
        active[k] = 1'b0;
      end else begin
        e_busy = 1'b1;
        if (d == 1) e_rd = 1'b1;
        if (d >= 3) e_tx = exp_bit(k, fbyte[k], (d - 3) / Cpb);
      end
    end
    check($sformatf("tx%0d", k),   32'(tx_w[k]),   32'(e_tx));
    check($sformatf("busy%0d", k), 32'(busy_w[k]), 32'(e_busy));
    check($sformatf("rden%0d", k), 32'(rd_en_w[k]), 32'(e_rd));
    if (rst) begin
      active[k] = 1'b0;
    end else if (!active[k] && en && !empty[k]) begin
      active[k] = 1'b1;
      t0[k]     = cyc;
      fbyte[k]  = fmem[k][head[k]];
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    for (int k = 0; k < 3; k++) check_dut(k);
    rd_seen = rd_en_w;
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 3; k++) begin
      if (rd_seen[k] && head[k] != tail[k]) begin
        rd_data[k] = fmem[k][head[k]];
        head[k]++;
      end else begin
        rd_data[k] = 8'($urandom);
      end
      empty[k] = (head[k] == tail[k]);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic push(input logic [7:0] b);
    for (int k = 0; k < 3; k++) begin
      if (tail[k] < 1024) begin
        fmem[k][tail[k]] = b;
        tail[k]++;
      end
      empty[k] = (head[k] == tail[k]);
    end
  endtask

  // Advance until instance 0 is d cycles past its decision cycle
  task automatic wait_offset(input int d, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (active[0] && (cyc - t0[0] == d)) break;
      cycle();
    end
    check("wait_offset", 32'(active[0] && (cyc - t0[0] == d)), 32'd1);
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; en = 1'b0; empty = 3'b111;
    tests = 0; fails = 0; cyc = 0; rd_seen = '0;
    for (int k = 0; k < 3; k++) begin
      rd_data[k] = 8'h00; head[k] = 0; tail[k] = 0;
      active[k] = 1'b0; t0[k] = 0; fbyte[k] = 8'h00;
    end
    repeat (2) @(posedge clk);
    #1;
    run(3);
    rst = 1'b0;

    push(8'hA5); en = 1'b1; run(60);
    push(8'h07); run(60);
    push(8'h00); push(8'hFF); run(120);
    run(100);

    push(8'h3C); push(8'hC3);
    wait_offset(3 + 4 * Cpb + 1, 50);
    en = 1'b0; run(120);
    en = 1'b1; run(120);

    push(8'h5A); push(8'h96);
    wait_offset(3 + 6 * Cpb + 1, 50);
    rst = 1'b1; cycle(); rst = 1'b0;
    run(150);

    for (int i = 0; i < 800; i++) begin
      en  = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 5) == 0) push(8'($urandom));
      cycle();
    end
    rst = 1'b0; en = 1'b1;
    run(400);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
